// File: rtl/row_dec_pkg.sv
// ---------------------------------------------------------------------------
// row_dec_pkg
// Shared definitions for the sequenced row decoder.
//   MODE_*  : request mode encodings carried on req_mode
//   state_e : sequencing engine states
// ---------------------------------------------------------------------------
package row_dec_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

endpackage

// File: rtl/row_decoder_seq_onehot_decode.sv
// ---------------------------------------------------------------------------
// onehot_decode
// Combinational binary-to-one-hot decoder for ROWS physical rows.
//   en     : when low the output is all-zero
//   addr   : binary row address (ADDR_W bits)
//   onehot : one-hot row vector; all-zero for addr >= ROWS
// ---------------------------------------------------------------------------
module onehot_decode
  import row_dec_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int ROWS   = 8
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [ROWS-1:0]   onehot
);

  // Only the ROWS legal codes have an output bit, so an out-of-range
  // address simply matches nothing and the vector stays zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < ROWS; i++) begin
      onehot[i] = en && (addr == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/row_decoder_seq.sv
// ---------------------------------------------------------------------------
// row_decoder_seq
// Registered one-hot row decoder with a sequencing engine. A request taken
// over a valid/ready handshake either holds one row for a programmable
// number of cycles (single mode) or sweeps consecutive rows up or down with
// wrap-around at ROWS, leaving a one-cycle all-zero gap between rows.
//
// Ports:
//   CLOCK_50  : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   req_valid : request present
//   req_ready : block can accept a request (state is IDLE)
//   req_addr  : start row address
//   req_mode  : 00 single, 01 scan up, 10 scan down, 11 reserved
//   req_len   : rows to drive in scan mode (0 means 1)
//   req_hold  : cycles each row stays asserted (0 means 1)
//   abort     : synchronous abort of an active request
//   row       : registered one-hot row select
//   cur_addr  : address of the row currently or last driven
//   busy      : high while a request is in progress
//   done      : one-cycle pulse on normal completion
//   err       : one-cycle pulse when a request is rejected
// ---------------------------------------------------------------------------
module row_decoder_seq
  import row_dec_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int ROWS   = 8,
  parameter int HOLD_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_mode,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [HOLD_W-1:0] req_hold,
  input  logic              abort,
  output logic [ROWS-1:0]   row,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W:0]   ROWS_EXT = (ADDR_W + 1)'(ROWS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mode_q, mode_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ROWS-1:0]   row_q, row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] load_addr;
  logic              row_load;
  logic              req_illegal;

  assign req_illegal = ({1'b0, req_addr} >= ROWS_EXT) || (req_mode == MODE_RSVD);

  // Scan stepping wraps at ROWS rather than at the natural 2**ADDR_W
  // boundary, so a non-power-of-two matrix never sees an unused code.
  always_comb begin
    next_addr = addr_q;
    if (mode_q == MODE_UP) begin
      next_addr = (addr_q == LAST_ROW) ? '0 : addr_q + ADDR_ONE;
    end else if (mode_q == MODE_DOWN) begin
      next_addr = (addr_q == '0) ? LAST_ROW : addr_q - ADDR_ONE;
    end
  end

  // hold_cnt counts the cycles still to go after the current one, so the
  // last hold cycle of a row is the one where it reads zero. The row
  // register is reloaded only while a row must stay (or become) asserted;
  // every other path lets it fall to zero, which gives the gap and the
  // idle cycle for free.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    row_load    = 1'b0;
    load_addr   = addr_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            err_d = 1'b1;
          end else begin
            state_d     = ACTIVE;
            addr_d      = req_addr;
            mode_d      = req_mode;
            remaining_d = ((req_mode == MODE_SINGLE) || (req_len == '0)) ? LEN_ONE : req_len;
            hold_d      = (req_hold == '0) ? HOLD_ONE : req_hold;
            hold_cnt_d  = (req_hold == '0) ? '0 : req_hold - HOLD_ONE;
            busy_d      = 1'b1;
            row_load    = 1'b1;
            load_addr   = req_addr;
          end
        end
      end

      ACTIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hold_cnt_q == '0) begin
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            busy_d  = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
          busy_d     = 1'b1;
          row_load   = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d    = ACTIVE;
          addr_d     = next_addr;
          hold_cnt_d = hold_q - HOLD_ONE;
          busy_d     = 1'b1;
          row_load   = 1'b1;
          load_addr  = next_addr;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  onehot_decode #(
    .ADDR_W (ADDR_W),
    .ROWS   (ROWS)
  ) u_decode (
    .en     (row_load),
    .addr   (load_addr),
    .onehot (row_d)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mode_q      <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      row_q       <= row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign row       = row_q;
  assign cur_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_row_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_row_decoder_seq
// Drives two decoders (ROWS=8 and ROWS=6, both ADDR_W=3) from the same
// request stream and compares every cycle of every request against a
// closed-form model of the row sequence.
// ---------------------------------------------------------------------------
module tb_row_decoder_seq;

  typedef struct packed {
    logic [7:0] row;
    logic       busy;
    logic       done;
    logic       err;
    logic       ready;
    logic [2:0] cur;
  } snap_t;

  localparam int MAXC = 300;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       abort;
  logic [2:0] req_addr;
  logic [1:0] req_mode;
  logic [3:0] req_len;
  logic [3:0] req_hold;

  logic       ready8, ready6, busy8, busy6, done8, done6, err8, err6;
  logic [7:0] row8;
  logic [5:0] row6;
  logic [2:0] cur8, cur6;

  int passed = 0;
  int total  = 0;

  snap_t obs [2][MAXC+1];
  int    q_addr, q_mode, q_len, q_hold, q_abort;
  int    q_prev   [2];
  int    prev_cur [2];

  always #5 CLOCK_50 = ~CLOCK_50;

  row_decoder_seq #(.ADDR_W(3), .ROWS(8), .HOLD_W(4), .LEN_W(4)) dut8 (
    .CLOCK_50 (CLOCK_50), .resetn (resetn),
    .req_valid(req_valid), .req_ready(ready8),
    .req_addr (req_addr), .req_mode (req_mode),
    .req_len  (req_len), .req_hold (req_hold),
    .abort    (abort), .row (row8), .cur_addr (cur8),
    .busy     (busy8), .done (done8), .err (err8)
  );

  row_decoder_seq #(.ADDR_W(3), .ROWS(6), .HOLD_W(4), .LEN_W(4)) dut6 (
    .CLOCK_50 (CLOCK_50), .resetn (resetn),
    .req_valid(req_valid), .req_ready(ready6),
    .req_addr (req_addr), .req_mode (req_mode),
    .req_len  (req_len), .req_hold (req_hold),
    .abort    (abort), .row (row6), .cur_addr (cur6),
    .busy     (busy6), .done (done6), .err (err6)
  );

  // Current outputs of one decoder, rows widened to 8 bits.
  function automatic snap_t snap(int d);
    snap_t s;
    if (d == 0) begin
      s.row = row8; s.busy = busy8; s.done = done8; s.err = err8; s.ready = ready8; s.cur = cur8;
    end else begin
      s.row = {2'b00, row6}; s.busy = busy6; s.done = done6; s.err = err6; s.ready = ready6; s.cur = cur6;
    end
    return s;
  endfunction

  // Expected outputs c cycles after the accepting edge. A request of n rows
  // held h cycles each occupies T = n*h + (n-1) cycles (rows plus gaps);
  // row k is (start +/- k) mod rows; cycle T+1 carries the done pulse.
  function automatic snap_t model(int d, int c);
    snap_t s;
    int r, n, h, t, j, ce, k, a;
    s = '0;
    s.ready = 1'b1;
    r = (d == 0) ? 8 : 6;
    if (q_addr >= r || q_mode == 3) begin
      s.err = (c == 1);
      s.cur = 3'(q_prev[d]);
      return s;
    end
    n  = (q_mode == 0 || q_len == 0) ? 1 : q_len;
    h  = (q_hold == 0) ? 1 : q_hold;
    t  = n * h + n - 1;
    j  = (q_abort >= 1 && q_abort <= t) ? q_abort : 0;
    ce = (j != 0 && c > j) ? j : ((c > t) ? t : c);
    k  = (ce - 1) / (h + 1);
    a  = (q_mode == 2) ? ((((q_addr - k) % r) + r) % r) : ((q_addr + k) % r);
    s.cur = 3'(a);
    if (j != 0 && c > j) return s;
    if (c > t) begin
      s.done = (c == t + 1);
      return s;
    end
    s.busy  = 1'b1;
    s.ready = 1'b0;
    if (((ce - 1) % (h + 1)) < h) s.row = 8'(1 << a);
    return s;
  endfunction

  // Cycles until a decoder is back in IDLE with its final pulse shown.
  function automatic int cycles_needed(int d);
    int r, n, h, t;
    r = (d == 0) ? 8 : 6;
    if (q_addr >= r || q_mode == 3) return 1;
    n = (q_mode == 0 || q_len == 0) ? 1 : q_len;
    h = (q_hold == 0) ? 1 : q_hold;
    t = n * h + n - 1;
    if (q_abort >= 1 && q_abort <= t) return q_abort + 1;
    return t + 1;
  endfunction

  // Presents one request at the current falling edge and records both
  // decoders' outputs for every following cycle. Called only while idle.
  task automatic run_request(input int addr, input int mode, input int len,
                             input int hold, input int abort_at, input int extra,
                             output int ncyc);
    snap_t t;
    int    n0, n1;
    q_addr = addr; q_mode = mode; q_len = len; q_hold = hold; q_abort = abort_at;
    q_prev[0] = prev_cur[0];
    q_prev[1] = prev_cur[1];
    n0 = cycles_needed(0);
    n1 = cycles_needed(1);
    ncyc = ((n0 > n1) ? n0 : n1) + extra;
    req_addr  = 3'(addr);
    req_mode  = 2'(mode);
    req_len   = 4'(len);
    req_hold  = 4'(hold);
    req_valid = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLOCK_50);
      obs[0][c] = snap(0);
      obs[1][c] = snap(1);
      req_valid = 1'b0;
      abort     = (c == abort_at);
    end
    abort = 1'b0;
    t = model(0, ncyc);
    prev_cur[0] = int'(t.cur);
    t = model(1, ncyc);
    prev_cur[1] = int'(t.cur);
  endtask

  task automatic test_reset();
    snap_t z, s;
    z = '0;
    z.ready = 1'b1;
    resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    for (int d = 0; d < 2; d++) begin
      s = snap(d);
      total++;
      if (s !== z) $display("[TB] FAIL reset_state dut%0d got=%b want=%b", d, s, z);
      else passed++;
    end
    resetn = 1'b1;
    @(negedge CLOCK_50);
    req_addr = 3'd2; req_mode = 2'b01; req_len = 4'd5; req_hold = 4'd2; req_valid = 1'b1;
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    @(negedge CLOCK_50);
    total++;
    if (row8 !== 8'h04 || row6 !== 6'h04)
      $display("[TB] FAIL reset_prescan got=%h/%h want=04/04", row8, row6);
    else passed++;
    #2 resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      s = snap(d);
      total++;
      if (s.row !== 8'h00 || s.busy !== 1'b0 || s.done !== 1'b0)
        $display("[TB] FAIL reset_async dut%0d got row=%h busy=%b done=%b want 00/0/0", d, s.row, s.busy, s.done);
      else passed++;
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    for (int d = 0; d < 2; d++) begin
      s = snap(d);
      total++;
      if (s !== z) $display("[TB] FAIL reset_release dut%0d got=%b want=%b", d, s, z);
      else passed++;
    end
    prev_cur[0] = 0;
    prev_cur[1] = 0;
  endtask

  task automatic test_single();
    int    n;
    snap_t e;
    run_request(5, 0, 0, 3, 0, 1, n);
    for (int d = 0; d < 2; d++)
      for (int c = 1; c <= n; c++) begin
        e = model(d, c);
        total++;
        if (obs[d][c] !== e) $display("[TB] FAIL single dut%0d cyc%0d got=%b want=%b", d, c, obs[d][c], e);
        else passed++;
      end
  endtask

  task automatic test_scan_up_wrap();
    int    n;
    snap_t e;
    run_request(6, 1, 4, 1, 0, 1, n);
    for (int d = 0; d < 2; d++)
      for (int c = 1; c <= n; c++) begin
        e = model(d, c);
        total++;
        if (obs[d][c] !== e) $display("[TB] FAIL scan_up dut%0d cyc%0d got=%b want=%b", d, c, obs[d][c], e);
        else passed++;
      end
    total++;
    if (cur8 !== 3'd1) $display("[TB] FAIL scan_up_last got=%0d want=1", cur8);
    else passed++;
  endtask

  task automatic test_scan_down();
    int    n;
    snap_t e;
    run_request(1, 2, 3, 2, 0, 1, n);
    for (int d = 0; d < 2; d++)
      for (int c = 1; c <= n; c++) begin
        e = model(d, c);
        total++;
        if (obs[d][c] !== e) $display("[TB] FAIL scan_down dut%0d cyc%0d got=%b want=%b", d, c, obs[d][c], e);
        else passed++;
      end
  endtask

  task automatic test_errors();
    int    n;
    snap_t e;
    int    tab [3][4] = '{'{7, 0, 0, 1}, '{2, 3, 5, 2}, '{3, 1, 0, 0}};
    for (int i = 0; i < 3; i++) begin
      run_request(tab[i][0], tab[i][1], tab[i][2], tab[i][3], 0, 1, n);
      for (int d = 0; d < 2; d++)
        for (int c = 1; c <= n; c++) begin
          e = model(d, c);
          total++;
          if (obs[d][c] !== e) $display("[TB] FAIL errors%0d dut%0d cyc%0d got=%b want=%b", i, d, c, obs[d][c], e);
          else passed++;
        end
    end
  endtask

  task automatic test_abort();
    int    n;
    snap_t e;
    int    tab [5][6] = '{'{3, 1, 4, 2, 4, 0}, '{0, 1, 2, 1, 1, 0}, '{5, 0, 0, 2, 0, 1},
                          '{4, 0, 0, 3, 3, 1}, '{2, 2, 3, 1, 2, 1}};
    for (int i = 0; i < 5; i++) begin
      run_request(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5], n);
      for (int d = 0; d < 2; d++)
        for (int c = 1; c <= n; c++) begin
          e = model(d, c);
          total++;
          if (obs[d][c] !== e) $display("[TB] FAIL abort%0d dut%0d cyc%0d got=%b want=%b", i, d, c, obs[d][c], e);
          else passed++;
        end
    end
  endtask

  task automatic test_back_to_back();
    int    n;
    snap_t e;
    int    tab [3][4] = '{'{0, 1, 2, 1}, '{7, 2, 2, 2}, '{6, 1, 3, 1}};
    for (int i = 0; i < 3; i++) begin
      run_request(tab[i][0], tab[i][1], tab[i][2], tab[i][3], 0, (i == 2) ? 1 : 0, n);
      for (int d = 0; d < 2; d++)
        for (int c = 1; c <= n; c++) begin
          e = model(d, c);
          total++;
          if (obs[d][c] !== e) $display("[TB] FAIL b2b%0d dut%0d cyc%0d got=%b want=%b", i, d, c, obs[d][c], e);
          else passed++;
        end
    end
  endtask

  task automatic test_random();
    int    n, ab;
    snap_t e;
    for (int i = 0; i < 30; i++) begin
      ab = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 14));
      run_request(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  ab, int'($urandom_range(0, 1)), n);
      for (int d = 0; d < 2; d++)
        for (int c = 1; c <= n; c++) begin
          e = model(d, c);
          total++;
          if (obs[d][c] !== e)
            $display("[TB] FAIL random%0d dut%0d cyc%0d req=%0d/%0d/%0d/%0d/%0d got=%b want=%b",
                     i, d, c, q_addr, q_mode, q_len, q_hold, q_abort, obs[d][c], e);
          else passed++;
        end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    abort     = 1'b0;
    req_addr  = '0;
    req_mode  = '0;
    req_len   = '0;
    req_hold  = '0;
    prev_cur[0] = 0;
    prev_cur[1] = 0;
    test_reset();
    test_single();
    test_scan_up_wrap();
    test_scan_down();
    test_errors();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/row_decoder_seq.md
Name: row_decoder_seq

Overview:
Parametrised, registered one-hot row decoder with a sequencing engine for the memory-matrix row path. It accepts an address request over a valid/ready handshake and drives one one-hot row. In single mode it holds one row for a programmable number of cycles. In scan modes it sweeps consecutive rows up or down with wrap-around, inserting a break-before-make gap between rows. It sits between the memory controller and the row drivers of the N-row matrix.

Parameters:
ADDR_W, 3, address width in bits.
ROWS, 8, number of physical rows; legal range 2..2**ADDR_W; addresses >= ROWS are illegal.
HOLD_W, 4, width of the per-row hold-count input.
LEN_W, 4, width of the scan-length input.

Ports:
CLOCK_50  in  1  system clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_addr  in  ADDR_W  start row address.
req_mode  in  2  00 single, 01 scan up, 10 scan down, 11 reserved.
req_len  in  LEN_W  rows to drive in scan mode; 0 is treated as 1; ignored in single mode.
req_hold  in  HOLD_W  cycles each row stays asserted; 0 is treated as 1.
abort  in  1  synchronous abort.
row  out  ROWS  registered one-hot row select; all-zero when idle or in gap.
cur_addr  out  ADDR_W  address of the row currently or last driven.
busy  out  1  high in ACTIVE or GAP.
done  out  1  one-cycle pulse when a request completes normally.
err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values (asynchronous, resetn=0): state IDLE; row=0; cur_addr=0; busy=0; done=0; err=0; all internal counters 0. Outputs stay at these values while resetn is low.
- Reset mid-operation: row drops to 0 immediately (asynchronously); no done is pulsed.
- All outputs are registered except req_ready, which is (state==IDLE).
- Handshake: a request is accepted on a rising edge where req_valid and req_ready are both 1. Request fields are sampled only on acceptance. req_valid while busy is ignored; it is neither queued nor flagged.
- Rejection: on acceptance with req_addr>=ROWS or req_mode==11:
  - err pulses in the next cycle.
  - State stays IDLE; row and cur_addr are unchanged.
- IDLE -> ACTIVE on a valid acceptance:
  - Latch addr, mode, remaining = (len==0 ? 1 : len) (forced to 1 in single mode), and hold = (hold==0 ? 1 : hold).
  - row[addr] becomes 1 in the cycle after acceptance (latency 1); cur_addr=addr; busy=1.
- ACTIVE: the row is asserted for exactly hold cycles. On the last hold cycle, remaining decrements:
  - If remaining reaches 0: go to IDLE, row=0, busy=0, and done pulses in that same cycle.
  - Otherwise: go to GAP.
- GAP: exactly one cycle with row=0 and busy=1. The next address is computed and the state moves to ACTIVE, asserting the new row the following cycle.
- Address stepping: scan up goes ROWS-1 -> 0; scan down goes 0 -> ROWS-1. Wrap is at ROWS, not 2**ADDR_W. Width is ADDR_W with no overflow beyond ROWS-1.
- Scans with len > ROWS revisit rows; this is legal.
- abort: in ACTIVE or GAP, go to IDLE next cycle with row=0, busy=0, and no done pulse. abort in IDLE has no effect. abort has priority over hold expiry in the same cycle.
- Invariant: at most one row bit is high in any cycle; a row never changes without an intervening all-zero cycle.
- Back-to-back: the cycle the block returns to IDLE, req_ready=1, so a new request can be accepted with one idle cycle (row=0) between requests.

Decomposition:
- Shared package row_dec_pkg:
  - mode encodings (MODE_SINGLE, MODE_UP, MODE_DOWN, MODE_RSVD);
  - state enum (IDLE, ACTIVE, GAP).
- One sub-module, onehot_decode (parametrised ADDR_W/ROWS, combinational, enable input, outputs zero for addr>=ROWS). The FSM registers its output into row.

Test Plan:
- Reset: drive resetn=0 mid-scan -> row=0, busy=0, done=0 at once; req_ready=1 after release.
- Single: addr=5, mode=00, hold=3 -> row=8'b0010_0000 for 3 cycles starting 1 cycle after acceptance, then row=0 with done pulsed for 1 cycle.
- Scan up with wrap: addr=6, mode=01, len=4, hold=1, ROWS=8 -> rows 6,7,0,1, each followed by a 1-cycle zero gap; done after row 1; cur_addr=1.
- Scan down with ROWS=6, ADDR_W=3: addr=1, mode=10, len=3 -> rows 1,0,5; row is never an out-of-range bit.
- Errors: addr=7 with ROWS=6, or mode=11 -> err pulse, row stays 0, busy=0; hold=0 and len=0 behave as 1.
- Abort: abort in the 2nd row of an up-scan -> row=0 and busy=0 next cycle, no done; a new request is accepted immediately after; abort together with hold expiry gives no done.
